// File: rtl/fsk_pkg.sv
// Shared types and default sizing for the FSK bit sequencer.
package fsk_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} fsk_state_e;
  localparam int BIT_PERIOD_DEF = 10000;
  localparam int DATA_BITS_DEF  = 8;
endpackage

// File: rtl/fsk_bit_timer.sv
// Bit-period timer: counts 0..BIT_PERIOD-1 while run is high, pulses bit_end on the last count.
module fsk_bit_timer #(
  parameter int BIT_PERIOD = fsk_pkg::BIT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);
  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign bit_end = run && (cnt == CW'(BIT_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (!run || bit_end) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fsk_bit_sequencer.sv
// Frames a payload word as start/data/[parity]/stop bits and drives mark/space tone enables.
// Define FSK_PARITY_EN to insert an even-parity bit between the payload and the stop bit.
module fsk_bit_sequencer
  import fsk_pkg::*;
#(
  parameter int BIT_PERIOD = BIT_PERIOD_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tone_en_0,
  output logic                 tone_en_1,
  output logic                 busy
);
  localparam int CW = $clog2(DATA_BITS + 1);

  fsk_state_e           state, nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [CW-1:0]        bit_cnt;
  logic                 bit_end, load, shift, tone_bit, active, par_bit;

  fsk_bit_timer #(.BIT_PERIOD(BIT_PERIOD)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state != IDLE),
    .bit_end (bit_end)
  );

`ifdef FSK_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       par_bit <= 1'b0;
    else if (load) par_bit <= ^data_in;
  end
`else
  assign par_bit = 1'b0;
`endif

  always_comb begin
    nxt   = state;
    load  = 1'b0;
    shift = 1'b0;
    case (state)
      IDLE:   if (data_valid && data_ready) begin nxt = START; load = 1'b1; end
      START:  if (bit_end) nxt = DATA;
      DATA:   if (bit_end) begin
                shift = 1'b1;
                if (bit_cnt == CW'(DATA_BITS - 1))
`ifdef FSK_PARITY_EN
                  nxt = PARITY;
`else
                  nxt = STOP;
`endif
              end
      PARITY: if (bit_end) nxt = STOP;
      STOP:   if (bit_end) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Tone outputs are registered from the next state so each bit appears the cycle it begins.
  always_comb begin
    shreg_nxt = shreg;
    if (load)       shreg_nxt = data_in;
    else if (shift) shreg_nxt = shreg >> 1;
    active   = (nxt != IDLE);
    tone_bit = 1'b0;
    case (nxt)
      DATA:    tone_bit = shreg_nxt[0];
      PARITY:  tone_bit = par_bit;
      STOP:    tone_bit = 1'b1;
      default: tone_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      tone_en_0  <= 1'b0;
      tone_en_1  <= 1'b0;
      busy       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      state      <= nxt;
      shreg      <= shreg_nxt;
      if (load)       bit_cnt <= '0;
      else if (shift) bit_cnt <= bit_cnt + 1'b1;
      tone_en_0  <= active && !tone_bit;
      tone_en_1  <= active && tone_bit;
      busy       <= active;
      data_ready <= !active;
    end
  end
endmodule

// File: tb/tb_fsk_bit_sequencer.sv
// Self-checking bench for fsk_bit_sequencer against a frame-level bit model.
module tb_fsk_bit_sequencer;
  localparam int BP = 4;
  localparam int DB = 8;
`ifdef FSK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = (2 + DB + PAR) * BP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DB-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready, tone_en_0, tone_en_1, busy;
  int total = 0;
  int bad   = 0;

  fsk_bit_sequencer #(.BIT_PERIOD(BP), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tone_en_0  (tone_en_0),
    .tone_en_1  (tone_en_1),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  a_tone_excl: assert property (@(posedge clk) !(tone_en_0 && tone_en_1));

  // Expected line bit for cycle k of a frame carrying d.
  function automatic logic exp_bit(input logic [DB-1:0] d, input int k);
    int b;
    b = k / BP;
    if (b == 0)               return 1'b0;
    if (b <= DB)              return d[b-1];
    if (PAR == 1 && b == DB+1) return ^d;
    return 1'b1;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({data_ready, busy, tone_en_1, tone_en_0} !== 4'b0000) begin
        bad++; $display("FAIL reset_hold got=%b exp=0000", {data_ready, busy, tone_en_1, tone_en_0});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({data_ready, busy, tone_en_1, tone_en_0} !== 4'b1000) begin
      bad++; $display("FAIL reset_release got=%b exp=1000", {data_ready, busy, tone_en_1, tone_en_0});
    end
  endtask

  task automatic test_frame(input logic [DB-1:0] d);
    logic e;
    total++;
    if (data_ready !== 1'b1) begin bad++; $display("FAIL frame_ready got=%b exp=1", data_ready); end
    data_in = d; data_valid = 1'b1;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      data_valid = 1'b0; data_in = DB'($urandom);
      e = exp_bit(d, k);
      total++;
      if ({data_ready, busy, tone_en_1, tone_en_0} !== {1'b0, 1'b1, e, ~e}) begin
        bad++; $display("FAIL frame d=%h k=%0d got=%b exp=%b", d, k,
                        {data_ready, busy, tone_en_1, tone_en_0}, {1'b0, 1'b1, e, ~e});
      end
    end
    @(negedge clk);
    total++;
    if ({data_ready, busy, tone_en_1, tone_en_0} !== 4'b1000) begin
      bad++; $display("FAIL frame_end d=%h got=%b exp=1000", d, {data_ready, busy, tone_en_1, tone_en_0});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) test_frame(DB'($urandom));
  endtask

  task automatic test_back_to_back();
    logic e;
    data_in = 8'h00; data_valid = 1'b1;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      data_in = 8'hFF;
      e = exp_bit(8'h00, k);
      total++;
      if ({busy, tone_en_1, tone_en_0} !== {1'b1, e, ~e}) begin
        bad++; $display("FAIL b2b_f1 k=%0d got=%b exp=%b", k, {busy, tone_en_1, tone_en_0}, {1'b1, e, ~e});
      end
    end
    @(negedge clk);
    total++;
    if ({data_ready, busy, tone_en_1, tone_en_0} !== 4'b1000) begin
      bad++; $display("FAIL b2b_gap got=%b exp=1000", {data_ready, busy, tone_en_1, tone_en_0});
    end
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      data_valid = 1'b0;
      e = exp_bit(8'hFF, k);
      total++;
      if ({busy, tone_en_1, tone_en_0} !== {1'b1, e, ~e}) begin
        bad++; $display("FAIL b2b_f2 k=%0d got=%b exp=%b", k, {busy, tone_en_1, tone_en_0}, {1'b1, e, ~e});
      end
    end
    @(negedge clk);
    total++;
    if ({data_ready, busy} !== 2'b10) begin bad++; $display("FAIL b2b_end got=%b exp=10", {data_ready, busy}); end
  endtask

  task automatic test_ignore_busy();
    logic e;
    data_in = 8'hA5; data_valid = 1'b1;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      data_valid = (k == 13);
      data_in    = (k == 13) ? 8'h3C : 8'hA5;
      e = exp_bit(8'hA5, k);
      total++;
      if ({busy, tone_en_1, tone_en_0} !== {1'b1, e, ~e}) begin
        bad++; $display("FAIL ignore k=%0d got=%b exp=%b", k, {busy, tone_en_1, tone_en_0}, {1'b1, e, ~e});
      end
    end
    data_valid = 1'b0;
    for (int k = 0; k < 2*BP; k++) begin
      @(negedge clk);
      total++;
      if ({data_ready, busy, tone_en_1, tone_en_0} !== 4'b1000) begin
        bad++; $display("FAIL ignore_idle k=%0d got=%b exp=1000", k, {data_ready, busy, tone_en_1, tone_en_0});
      end
    end
  endtask

  task automatic test_reset_mid();
    data_in = 8'h5A; data_valid = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      data_valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, tone_en_1, tone_en_0, data_ready} !== 4'b0000) begin
      bad++; $display("FAIL rst_async got=%b exp=0000", {busy, tone_en_1, tone_en_0, data_ready});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3*BP; k++) begin
      @(negedge clk);
      total++;
      if ({data_ready, busy, tone_en_1, tone_en_0} !== 4'b1000) begin
        bad++; $display("FAIL rst_after k=%0d got=%b exp=1000", k, {data_ready, busy, tone_en_1, tone_en_0});
      end
    end
    test_frame(8'h81);
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h07);
    test_random();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fsk_bit_sequencer.md
FSK_BIT_SEQUENCER -- requirements
Module: fsk_bit_sequencer

Interface
REQ-001 SHALL have parameter BIT_PERIOD, default 10000: clock cycles per transmitted bit (min 2).
REQ-002 SHALL have parameter DATA_BITS, default 8: payload bits per frame (1..16).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_in  input  DATA_BITS  payload byte to transmit.
REQ-006 SHALL have port data_valid  input  1  source offers data_in.
REQ-007 SHALL have port data_ready  output  1  block accepts data_in this cycle.
REQ-008 SHALL have port tone_en_0  output  1  space-tone enable; drives the valid input of the space-tone PDM channel.
REQ-009 SHALL have port tone_en_1  output  1  mark-tone enable; drives the valid input of the mark-tone PDM channel.
REQ-010 SHALL have port busy  output  1  frame in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL assert data_ready only in IDLE; a transfer occurs on a clock edge where data_valid and data_ready are both high.
REQ-013 SHALL capture data_in into an internal shift register on transfer and enter START on the same edge.
REQ-014 SHALL, from the cycle after transfer, emit START (space), DATA_BITS payload bits LSB first, optional PARITY, then STOP (mark).
REQ-015 SHALL hold each bit for exactly BIT_PERIOD cycles using a bit timer counting 0..BIT_PERIOD-1 that wraps to 0 on bit advance.
REQ-016 SHALL drive a bit value of 0 as tone_en_0=1, tone_en_1=0, and a bit value of 1 as tone_en_0=0, tone_en_1=1; outputs are registered.
REQ-017 SHALL never assert tone_en_0 and tone_en_1 in the same cycle.
REQ-018 SHALL drive tone_en_0=0, tone_en_1=0 and busy=0 in IDLE.
REQ-019 SHALL assert busy in every non-IDLE state.
REQ-020 SHALL count payload bits with a counter of width $clog2(DATA_BITS+1); the DATA-to-next-state transition occurs when the last bit's period ends.
REQ-021 SHALL return to IDLE after STOP's final cycle; data_ready rises on the first cycle after STOP, giving a one-cycle IDLE gap between back-to-back frames.
REQ-022 SHALL ignore data_valid while busy; data_in changes during a frame have no effect.
REQ-023 SHALL make frame length (2+DATA_BITS[+1 with parity])*BIT_PERIOD cycles.

Reset
REQ-024 SHALL, while rst is high, force state=IDLE, timers=0, shift register=0, tone_en_0=0, tone_en_1=0, busy=0, data_ready=0, asynchronously.
REQ-025 SHALL discard any partial frame on reset mid-operation, with no resumption.
REQ-026 SHALL assert data_ready on the first clock edge after rst deasserts.

Configuration
REQ-027 SHALL, with macro FSK_PARITY_EN defined, insert a PARITY state after DATA that transmits the even-parity bit (XOR of payload) for BIT_PERIOD cycles.
REQ-028 SHALL, without FSK_PARITY_EN, omit the PARITY state entirely and go from DATA directly to STOP.

Structure
REQ-029 SHALL place the FSM state typedef and the default BIT_PERIOD/DATA_BITS constants in shared package fsk_pkg.
REQ-030 SHALL implement the bit timer as sub-module fsk_bit_timer (inputs clk, rst, run; output bit_end pulse when count reaches BIT_PERIOD-1).

Verification (BIT_PERIOD=4, DATA_BITS=8)
REQ-031 SHALL cover: transfer 0xA5 -> tone_en_1 pattern per 4-cycle bit 0,1,0,1,0,0,1,0,1,1 (start, LSB-first payload, stop); 40 busy cycles; data_ready high on cycle 41.
REQ-032 SHALL cover: data_valid held high with 0x00 then 0xFF -> second transfer on the first data_ready cycle after frame one; exactly one idle cycle with both tones low between frames.
REQ-033 SHALL cover: data_valid pulsed with 0x3C during frame DATA bit 2 -> no transfer, frame one bits unchanged, no second frame.
REQ-034 SHALL cover: rst asserted mid DATA bit 3 -> tone_en_0, tone_en_1 and busy low with no clock edge; after release, data_ready=1 and no tone activity until a new transfer.
REQ-035 SHALL cover: FSK_PARITY_EN defined, transfer 0x07 -> parity bit 1 (mark) for 4 cycles before stop; 44 busy cycles.
REQ-036 SHALL cover: a concurrent assertion that tone_en_0 and tone_en_1 are never both high, checked across all scenarios.
